// File: rtl/uart_msg_streamer.sv
// uart_msg_streamer: repeatedly streams a fixed message into a UART byte
// transmitter over valid/ready. XON/XOFF from the receiver pauses the message
// stream, other received bytes are echoed through a small FIFO that has
// priority over message bytes, and completed messages are counted.
module uart_msg_streamer #(
  parameter int unsigned          MSG_LEN    = 14,
  parameter logic [MSG_LEN*8-1:0] MSG        = "Hello World!\r\n",
  parameter int unsigned          GAP_CYCLES = 0,
  parameter int unsigned          ECHO       = 1,
  parameter int unsigned          ECHO_DEPTH = 4,
  parameter int unsigned          COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  output logic               paused,
  output logic               overflow,
  output logic [COUNT_W-1:0] msg_count
);

  localparam int unsigned     IW       = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int unsigned     AW       = $clog2(ECHO_DEPTH);
  localparam int unsigned     CW       = AW + 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(MSG_LEN - 1);
  localparam logic [23:0]     GAP_LOAD = 24'(GAP_CYCLES);
  localparam logic [CW-1:0]   FULL_LVL = CW'(ECHO_DEPTH);

  typedef enum logic {SEND, GAP} state_t;

  state_t        state, state_next;
  logic [IW-1:0] index, index_next;
  logic [23:0]   gap_cnt, gap_next;
  logic          paused_next;
  logic          tx_is_msg;

  logic [7:0]    msg_rom [MSG_LEN];
  logic [7:0]    mem [ECHO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_after;
  logic [CW-1:0] level, level_after_pop;

  logic xfer, msg_xfer, echo_pop, last_byte;
  logic is_xoff, is_xon, echo_req, push_ok, echo_drop, slot_free;

  assign xfer      = tx_valid & tx_ready;
  assign msg_xfer  = xfer & tx_is_msg;
  assign echo_pop  = xfer & ~tx_is_msg;
  assign last_byte = (index == LAST_IDX);
  assign is_xoff   = rx_valid && (rx_data == 8'h13);
  assign is_xon    = rx_valid && (rx_data == 8'h11);
  assign echo_req  = rx_valid && (ECHO != 0) && !is_xoff && !is_xon;
  assign slot_free = !tx_valid || tx_ready;

  // Unpack the message so the leftmost character sits at index 0.
  always_comb begin
    for (int unsigned i = 0; i < MSG_LEN; i++) begin
      msg_rom[i] = MSG[(MSG_LEN-1-i)*8 +: 8];
    end
  end

  // Next-state logic: message position, gap countdown and SEND/GAP sequencing.
  always_comb begin
    state_next = state;
    index_next = index;
    gap_next   = gap_cnt;
    case (state)
      SEND: begin
        if (msg_xfer) begin
          if (last_byte) begin
            index_next = '0;
            if (GAP_CYCLES != 0) begin
              state_next = GAP;
              gap_next   = GAP_LOAD;
            end
          end else begin
            index_next = index + IW'(1);
          end
        end
      end
      GAP: begin
        gap_next = gap_cnt - 24'd1;
        if (gap_cnt <= 24'd1) state_next = SEND;
      end
      default: state_next = SEND;
    endcase
  end

  // Pause flag as it will be after this edge, so an XOFF blocks selection at once.
  always_comb begin
    paused_next = paused;
    if (is_xoff) paused_next = 1'b1;
    if (is_xon)  paused_next = 1'b0;
  end

  // FIFO bookkeeping: the pop is applied before the push so a full FIFO that
  // is draining this cycle still accepts the incoming byte.
  always_comb begin
    level_after_pop = level - CW'(echo_pop);
    rd_after        = rd_ptr + AW'(echo_pop);
    push_ok         = echo_req && (level_after_pop != FULL_LVL);
    echo_drop       = echo_req && !push_ok;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEND;
    else     state <= state_next;
  end

  // Message index, gap counter and completed-message counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index     <= '0;
      gap_cnt   <= '0;
      msg_count <= '0;
    end else begin
      index   <= index_next;
      gap_cnt <= gap_next;
      if (msg_xfer && last_byte) msg_count <= msg_count + COUNT_W'(1);
    end
  end

  // Pause control and sticky echo-overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paused   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      paused <= paused_next;
      if (echo_drop) overflow <= 1'b1;
    end
  end

  // Echo FIFO storage (contents need no reset; level gates every read).
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

  // Echo FIFO pointers and fill level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      rd_ptr <= rd_after;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      level <= level_after_pop + CW'(push_ok);
    end
  end

  // Slot selection: an offer is held until it transfers; a new byte is chosen
  // only when the channel is free, echo first, then the next message byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      tx_is_msg <= 1'b0;
    end else if (slot_free) begin
      if (level_after_pop != '0) begin
        tx_valid  <= 1'b1;
        tx_data   <= mem[rd_after];
        tx_is_msg <= 1'b0;
      end else if (state_next == SEND && !paused_next) begin
        tx_valid  <= 1'b1;
        tx_data   <= msg_rom[index_next];
        tx_is_msg <= 1'b1;
      end else begin
        tx_valid  <= 1'b0;
        tx_is_msg <= 1'b0;
      end
    end
  end

endmodule
